// File: rtl/fpadd_sched_pkg.sv
// Shared defaults and types for the two-requester floating-point adder scheduler.
package fpadd_sched_pkg;

  localparam int W_DEF     = 64;
  localparam int LAT_DEF   = 3;
  localparam int DEPTH_DEF = 4;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/fpadd_sched_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; one instance per requester.
module rsp_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: storage is not reset; pointers and count define validity, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_sched.sv
// Arbitrates two requesters onto one pipelined adder and routes results back by tag.
module fpadd_sched
  import fpadd_sched_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req0_sub,
  input  logic         req1_sub,
  output logic         add_valid,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_sub,
  input  logic         res_valid,
  input  logic [W-1:0] add_res,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp0_res,
  output logic [W-1:0] rsp1_res,
  output logic         err
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count0, count1;
  logic [CW-1:0] inflight0, inflight1;
  logic [CW:0]   load0, load1;
  logic          full0, full1;
  logic          elig0, elig1;
  logic          grant0, grant1, grant_any;
  req_id_t       grant_id;
  req_id_t       last_grant;
  tag_t          tags [LAT+1];
  tag_t          tail;
  logic          wb0, wb1;
  logic          err_q;

  // Credit covers both results still in the adder and results parked in the FIFO.
  assign load0 = {1'b0, inflight0} + {1'b0, count0};
  assign load1 = {1'b0, inflight1} + {1'b0, count1};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    elig0  = 1'b0;
    elig1  = 1'b0;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      elig0 = req0_valid && (load0 < (CW+1)'(DEPTH));
      elig1 = req1_valid && (load1 < (CW+1)'(DEPTH));
    end
    grant0 = elig0 && (!elig1 || (last_grant == 1'b1));
    grant1 = elig1 && (!elig0 || (last_grant == 1'b0));
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign grant_any  = grant0 || grant1;
  assign grant_id   = grant1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_valid  <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      add_sub    <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      add_valid <= grant_any;
      if (grant_any) begin
        add_a      <= grant1 ? req1_a   : req0_a;
        add_b      <= grant1 ? req1_b   : req0_b;
        add_sub    <= grant1 ? req1_sub : req0_sub;
        last_grant <= grant_id;
      end
    end
  end

  // Stage 0 lines up with add_valid; stage LAT lines up with the returning result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= LAT; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: grant_any, id: grant_id};
      for (int i = 1; i <= LAT; i++) tags[i] <= tags[i-1];
    end
  end

  assign tail = tags[LAT];
  assign wb0  = res_valid && tail.valid && (tail.id == 1'b0);
  assign wb1  = res_valid && tail.valid && (tail.id == 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight0 <= '0;
      inflight1 <= '0;
    end else begin
      case ({grant0, wb0})
        2'b10:   inflight0 <= inflight0 + 1'b1;
        2'b01:   inflight0 <= inflight0 - 1'b1;
        default: inflight0 <= inflight0;
      endcase
      case ({grant1, wb1})
        2'b10:   inflight1 <= inflight1 + 1'b1;
        2'b01:   inflight1 <= inflight1 - 1'b1;
        default: inflight1 <= inflight1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((res_valid != tail.valid) || (wb0 && full0) || (wb1 && full1)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (wb0),
    .din   (add_res),
    .pop   (rsp0_ready),
    .dout  (rsp0_res),
    .count (count0),
    .full  (full0)
  );

  rsp_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (wb1),
    .din   (add_res),
    .pop   (rsp1_ready),
    .dout  (rsp1_res),
    .count (count1),
    .full  (full1)
  );

  assign rsp0_valid = (count0 != '0);
  assign rsp1_valid = (count1 != '0);

endmodule

// File: tb/tb_fpadd_sched.sv
// Self-checking bench: real-arithmetic adder model, scoreboard of outstanding ops, directed corners.
module tb_fpadd_sched;
  import fpadd_sched_pkg::*;

  localparam int W     = W_DEF;
  localparam int LAT   = LAT_DEF;
  localparam int DEPTH = DEPTH_DEF;

  logic         clk, rst;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_sub, req1_sub;
  logic         add_valid, add_sub, res_valid;
  logic [W-1:0] add_a, add_b, add_res;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_res, rsp1_res;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  fpadd_sched #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_sub(req0_sub), .req1_sub(req1_sub),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
    .res_valid(res_valid), .add_res(add_res),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_res(rsp0_res), .rsp1_res(rsp1_res),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] fadd(input logic [63:0] a, input logic [63:0] b, input logic sub);
    real r;
    r = sub ? ($bitstoreal(a) - $bitstoreal(b)) : ($bitstoreal(a) + $bitstoreal(b));
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] rnd_op();
    int v;
    v = int'($urandom_range(0, 2000));
    return $realtobits(real'(v - 1000) / 4.0);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  // Shared adder: fixed LAT-cycle pipeline sharing rst, plus a hook to inject a stray result.
  logic         pv   [LAT];
  logic [W-1:0] pres [LAT];
  logic         inj;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      for (int i = LAT-1; i > 0; i--) begin
        pv[i]   <= pv[i-1];
        pres[i] <= pres[i-1];
      end
      pv[0]   <= add_valid;
      pres[0] <= fadd(add_a, add_b, add_sub);
    end
  end

  assign res_valid = pv[LAT-1] | inj;
  assign add_res   = pres[LAT-1];

  // Scoreboard: outstanding = accepted - delivered per requester; round-robin on ties.
  logic [63:0] expq0 [$];
  logic [63:0] expq1 [$];
  int          out0, out1, pops0, pops1, hs0, hs1;
  logic        lg;
  bit          chk_err;
  logic        e0, e1, g0, g1;

  always @(negedge clk) begin
    if (rst) begin
      check("outputs zero in reset",
            64'(|{req0_ready, req1_ready, add_valid, add_a, add_b, add_sub,
                  rsp0_valid, rsp1_valid, rsp0_res, rsp1_res, err}), 64'd0);
      expq0.delete();
      expq1.delete();
      out0 = 0;
      out1 = 0;
      lg   = 1'b1;
    end else begin
      e0 = req0_valid && (out0 < DEPTH);
      e1 = req1_valid && (out1 < DEPTH);
      g0 = e0 && (!e1 || lg == 1'b1);
      g1 = e1 && (!e0 || lg == 1'b0);
      check("req0_ready", 64'(req0_ready), 64'(g0));
      check("req1_ready", 64'(req1_ready), 64'(g1));
      if (expq0.size() == 0) check("rsp0_valid with nothing pending", 64'(rsp0_valid), 64'd0);
      if (expq1.size() == 0) check("rsp1_valid with nothing pending", 64'(rsp1_valid), 64'd0);
      if (rsp0_valid && rsp0_ready && expq0.size() != 0) begin
        check("rsp0_res order/value", rsp0_res, expq0.pop_front());
        out0--;
        pops0++;
      end
      if (rsp1_valid && rsp1_ready && expq1.size() != 0) begin
        check("rsp1_res order/value", rsp1_res, expq1.pop_front());
        out1--;
        pops1++;
      end
      if (req0_valid && req0_ready) begin
        expq0.push_back(fadd(req0_a, req0_b, req0_sub));
        out0++;
        hs0++;
        lg = 1'b0;
      end
      if (req1_valid && req1_ready) begin
        expq1.push_back(fadd(req1_a, req1_b, req1_sub));
        out1++;
        hs1++;
        lg = 1'b1;
      end
      if (chk_err) check("err stays low", 64'(err), 64'd0);
    end
  end

  typedef struct {
    logic        id;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic single_op(input vec_t v, input string name);
    int          hit;
    logic [63:0] got;
    bit          other;
    hit   = -1;
    got   = '0;
    other = 1'b0;
    tick();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    if (v.id) begin
      req1_valid = 1'b1; req1_a = v.a; req1_b = v.b; req1_sub = v.sub;
    end else begin
      req0_valid = 1'b1; req0_a = v.a; req0_b = v.b; req0_sub = v.sub;
    end
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int c = 1; c <= LAT + 8; c++) begin
      if (hit < 0 && (v.id ? rsp1_valid : rsp0_valid)) begin
        hit = c;
        got = v.id ? rsp1_res : rsp0_res;
      end
      if (v.id ? rsp0_valid : rsp1_valid) other = 1'b1;
      tick();
    end
    check({name, " latency"}, 64'(hit), 64'(LAT + 2));
    check({name, " result"}, got, v.exp);
    check({name, " other rsp idle"}, 64'(other), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, p0, p1;
    rst = 1'b1; inj = 1'b0; chk_err = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    req0_sub = 1'b0; req1_sub = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    lg = 1'b1; out0 = 0; out1 = 0; pops0 = 0; pops1 = 0; hs0 = 0; hs1 = 0;

    vecs[0] = '{1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000};
    vecs[1] = '{1'b1, 64'h4008000000000000, 64'h3FF0000000000000, 1'b1, 64'h4000000000000000};
    vecs[2] = '{1'b0, 64'h3FF8000000000000, 64'h3FE0000000000000, 1'b0, 64'h4000000000000000};
    vecs[3] = '{1'b1, 64'h4014000000000000, 64'h4014000000000000, 1'b1, 64'h0000000000000000};
    vecs[4] = '{1'b0, 64'hBFF0000000000000, 64'hBFF0000000000000, 1'b0, 64'hC000000000000000};
    vecs[5] = '{1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h4000000000000000};

    tick();
    check("reset req0_ready", 64'(req0_ready), 64'd0);
    check("reset add_valid", 64'(add_valid), 64'd0);
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Single operations from a table, each from an idle pipeline.
    for (int i = 0; i < 6; i++) single_op(vecs[i], $sformatf("vec%0d", i));

    // Tie from reset: alternate starting with requester 0.
    do_reset();
    p0 = pops0; p1 = pops1;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req0_a = rnd_op(); req0_b = rnd_op(); req1_a = rnd_op(); req1_b = rnd_op();
      @(negedge clk);
      check("tie single grant", 64'(req0_ready ^ req1_ready), 64'd1);
      check($sformatf("tie order %0d", k), 64'(req1_ready), 64'(k % 2));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (LAT + 8) tick();
    check("tie rsp0 count", 64'(pops0 - p0), 64'd2);
    check("tie rsp1 count", 64'(pops1 - p1), 64'd2);

    // Credit: blocked consumer limits grants to DEPTH, one pop frees one slot.
    rsp0_ready = 1'b0;
    req0_valid = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (req0_ready) n++;
      tick();
    end
    check("credit grants", 64'(n), 64'(DEPTH));
    check("credit stall ready", 64'(req0_ready), 64'd0);
    rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req0_ready) n++;
      tick();
    end
    check("credit after one pop", 64'(n), 64'd1);
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    repeat (LAT + 10) tick();

    // Random mixed traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      req0_valid = ($urandom_range(0, 1) == 1);
      req1_valid = ($urandom_range(0, 1) == 1);
      req0_a = rnd_op(); req0_b = rnd_op(); req0_sub = 1'($urandom_range(0, 1));
      req1_a = rnd_op(); req1_b = rnd_op(); req1_sub = 1'($urandom_range(0, 1));
      rsp0_ready = ($urandom_range(0, 9) < 7);
      rsp1_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (LAT + 2 * DEPTH + 8) tick();
    check("random q0 drained", 64'(expq0.size()), 64'd0);
    check("random q1 drained", 64'(expq1.size()), 64'd0);
    check("random no loss", 64'(hs0 + hs1), 64'(pops0 + pops1));
    check("random err", 64'(err), 64'd0);

    // Stray result with nothing in flight.
    chk_err = 1'b0;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    @(negedge clk);
    check("protocol err set", 64'(err), 64'd1);
    repeat (5) tick();
    check("protocol err sticky", 64'(err), 64'd1);
    do_reset();
    @(negedge clk);
    check("protocol err cleared", 64'(err), 64'd0);
    chk_err = 1'b1;

    // Reset with three operations in flight.
    tick();
    req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = rnd_op(); req1_b = rnd_op();
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = rnd_op(); req0_b = rnd_op();
    tick();
    req0_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("midflight outputs zero",
          64'(|{req0_ready, req1_ready, add_valid, add_a, add_b, add_sub,
                rsp0_valid, rsp1_valid, rsp0_res, rsp1_res, err}), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    req0_valid = 1'b0;
    single_op(vecs[0], "after reset");
    repeat (LAT + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 SHALL have parameter W, default 64: operand/result width (IEEE double).
REQ-002 SHALL have parameter LAT, default 3: fixed shared-adder latency, add_valid to res_valid, cycles (>=1).
REQ-003 SHALL have parameter DEPTH, default 4: per-requester response FIFO depth (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports req0_valid/req1_valid, input, 1 each: requester i has an operation.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted this cycle.
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b, input, W each: operands.
REQ-009 SHALL have ports req0_sub/req1_sub, input, 1 each: 1 = a-b, 0 = a+b.
REQ-010 SHALL have ports add_valid (output, 1), add_a/add_b (output, W) and add_sub (output, 1): issue to the shared adder.
REQ-011 SHALL have ports res_valid (input, 1) and add_res (input, W): adder result return.
REQ-012 SHALL have ports rsp0_valid/rsp1_valid (output, 1), rsp0_ready/rsp1_ready (input, 1) and rsp0_res/rsp1_res (output, W): per-requester results.
REQ-013 SHALL have port err, output, 1: sticky protocol-error flag.

Function
REQ-014 Requester i SHALL be eligible when reqi_valid=1 and inflight_i + count_i < DEPTH (credit check).
REQ-015 At most one requester SHALL be granted per cycle; reqi_ready = grant_i, combinational.
REQ-016 When exactly one requester is eligible, it SHALL be granted.
REQ-017 When both are eligible, the requester other than last_grant SHALL win; last_grant updates on every grant.
REQ-018 On grant, operands/sub SHALL be registered; add_valid=1 for exactly one cycle, the next cycle.
REQ-019 Sustained throughput SHALL be one issue per cycle.
REQ-020 A tag shift register of LAT+1 stages SHALL track {valid, id} aligned with each issue.
REQ-021 On res_valid, the tail tag SHALL select the FIFO that receives add_res.
REQ-022 res_valid with an invalid tail tag, or a valid tail tag without res_valid, SHALL set err; the result is dropped.
REQ-023 inflight_i SHALL increment on issue and decrement on write-back; simultaneous events SHALL leave it unchanged.
REQ-024 Latency from request handshake to rspi_valid SHALL be LAT+2 cycles when the FIFO is empty.
REQ-025 Results per requester SHALL be delivered in issue order.
REQ-026 rspi_valid = (count_i != 0); pop occurs on rspi_valid & rspi_ready.
REQ-027 Simultaneous push and pop SHALL keep count_i; DEPTH entries plus inflight never exceed DEPTH (by REQ-014).
REQ-028 A push to a full FIFO SHALL set err and drop the data; pop when empty SHALL be ignored.
REQ-029 Pointers SHALL wrap modulo DEPTH.
REQ-030 err SHALL remain 1 until reset.

Reset
REQ-031 rst SHALL asynchronously clear FIFOs, counts, inflight, tags, last_grant (=1, so req0 wins first tie), issue register, and err.
REQ-032 During rst, all outputs SHALL be 0, including reqi_ready, add_valid, and rspi_valid.
REQ-033 Reset mid-operation SHALL discard all in-flight work; the adder shares rst, and no res_valid is expected for pre-reset issues.

Structure
REQ-034 Package fpadd_sched_pkg SHALL hold W, LAT, DEPTH defaults, the tag struct {valid, id}, and the requester-id type.
REQ-035 Sub-module rsp_fifo (synchronous FIFO with count output) SHALL be instantiated once per requester.

Verification
REQ-036 Single op: req0 a=0x3FF0000000000000, b=0x4000000000000000, sub=0; model returns 0x4008000000000000 -> rsp0_valid at cycle LAT+2 with that value, rsp1_valid stays 0.
REQ-037 Tie: both valid for 4 cycles from reset -> grant order 0,1,0,1; each rsp FIFO receives 2 results in order.
REQ-038 Credit: rsp0_ready=0 and req0_valid held -> exactly DEPTH=4 grants, then req0_ready=0; one pop -> one further grant.
REQ-039 Back-to-back mixed: 8 ops alternating requesters with random rsp_ready -> no loss, per-requester order kept, err=0.
REQ-040 Protocol: inject res_valid with no issue -> err=1 next cycle and stays 1; rst clears it.
REQ-041 Reset mid-flight: assert rst with 3 ops in flight -> all outputs 0 immediately; after release, a new op completes in LAT+2 cycles.
